// File: rtl/kmeans_feeder_pkg.sv
// Shared sizing constants and state encoding for the k-means stream feeder.
package kmeans_feeder_pkg;

    localparam int unsigned N_MAX    = 1024;
    localparam int unsigned K_MAX    = 16;
    localparam int unsigned D        = 3;
    localparam int unsigned DATA_W   = 32;

    localparam int unsigned PT_DEPTH = D * N_MAX;
    localparam int unsigned CT_DEPTH = D * K_MAX;
    localparam int unsigned PT_AW    = $clog2(PT_DEPTH);
    localparam int unsigned CT_AW    = $clog2(CT_DEPTH);
    // Counters/pointers need one extra bit to hold a full-buffer value.
    localparam int unsigned PT_CW    = PT_AW + 1;
    localparam int unsigned CT_CW    = CT_AW + 1;

    localparam int unsigned STATE_W  = 3;
    localparam logic [STATE_W-1:0] S_IDLE    = 3'd0;
    localparam logic [STATE_W-1:0] S_START_1 = 3'd1;
    localparam logic [STATE_W-1:0] S_RUN_1   = 3'd2;
    localparam logic [STATE_W-1:0] S_START_2 = 3'd3;
    localparam logic [STATE_W-1:0] S_RUN_2   = 3'd4;
    localparam logic [STATE_W-1:0] S_DONE    = 3'd5;

endpackage

// File: rtl/kmeans_stream_feeder_buf.sv
// One buffered stream: dual-port RAM, write counter, read pointer and a
// registered show-ahead output that always holds mem[rd_ptr].
module feeder_buf #(
    parameter int unsigned AW     = 6,
    parameter int unsigned CW     = 7,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              cnt_clr,
    output logic [CW-1:0]     wr_cnt,
    input  logic              ptr_clr,
    input  logic              run,
    input  logic [CW-1:0]     target,
    input  logic              read,
    output logic [DATA_W-1:0] dout,
    output logic              empty_n,
    output logic              underrun
);

    logic [DATA_W-1:0] mem [0:(2**AW)-1];
    logic [CW-1:0]     rd_ptr;
    logic [CW-1:0]     rd_ptr_nxt;
    logic [AW-1:0]     rd_addr;
    logic              rd_adv;

    assign empty_n  = run && (rd_ptr < target);
    assign rd_adv   = read && empty_n;
    assign underrun = read && !empty_n;
    assign rd_addr  = rd_ptr_nxt[AW-1:0];

    // Next read pointer: restart at phase start, step on each accepted read.
    always_comb begin
        rd_ptr_nxt = rd_ptr;
        if (ptr_clr) begin
            rd_ptr_nxt = '0;
        end else if (rd_adv) begin
            rd_ptr_nxt = rd_ptr + CW'(1);
        end
    end

    // RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_cnt[AW-1:0]] <= wr_data;
        end
    end

    // Write counter doubles as the next write address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt <= '0;
        end else if (cnt_clr) begin
            wr_cnt <= '0;
        end else if (wr_en) begin
            wr_cnt <= wr_cnt + CW'(1);
        end
    end

    // Read pointer and show-ahead output, fetched with the next address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            dout   <= '0;
        end else begin
            rd_ptr <= rd_ptr_nxt;
            dout   <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/kmeans_stream_feeder.sv
// Feeder for the two-phase k-means core: buffers points and centres, then
// serves them over ap_fifo streams while sequencing both start/done phases.
module kmeans_stream_feeder
    import kmeans_feeder_pkg::*;
(
    input  logic              clk_in1,
    input  logic              reset,
    input  logic [31:0]       n_V,
    input  logic [7:0]        k_V,
    input  logic              ld_sel,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    input  logic              go,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output logic              err_underrun,
    output logic [31:0]       cycle_count,
    output logic              ap_start_1,
    input  logic              ap_done_1,
    output logic              ap_start_2,
    input  logic              ap_done_2,
    output logic [DATA_W-1:0] data_points_in_dout,
    output logic              data_points_in_empty_n,
    input  logic              data_points_in_read,
    output logic [DATA_W-1:0] centres_in_dout,
    output logic              centres_in_empty_n,
    input  logic              centres_in_read
);

    // Full-width target arithmetic: 3 * 2^32 needs 34 bits, 3 * 256 needs 10.
    localparam int unsigned PTW = 35;
    localparam int unsigned CTW = 10;

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_nxt;
    logic               go_acc;
    logic               go_rej;
    logic [PTW-1:0]     pt_tgt_live;
    logic [CTW-1:0]     ct_tgt_live;
    logic [PT_CW-1:0]   pt_cnt;
    logic [PT_CW-1:0]   pt_tgt;
    logic [CT_CW-1:0]   ct_cnt;
    logic [CT_CW-1:0]   ct_tgt;
    logic               is_idle;
    logic               in_run;
    logic               ptr_clr;
    logic               cnt_clr;
    logic               pt_room;
    logic               ct_room;
    logic               go_ok;
    logic               pt_wr;
    logic               ct_wr;
    logic               pt_under;
    logic               ct_under;

    assign is_idle = (state == S_IDLE);
    assign in_run  = (state == S_RUN_1) || (state == S_RUN_2);
    assign ptr_clr = (state == S_START_1) || (state == S_START_2);
    assign cnt_clr = (state == S_DONE);

    assign pt_tgt_live = PTW'(D) * (PTW'(n_V) + PTW'(1));
    assign ct_tgt_live = CTW'(D) * (CTW'(k_V) + CTW'(1));

    // A buffer accepts words up to its target, never past its physical depth.
    assign pt_room  = (PTW'(pt_cnt) < pt_tgt_live) && (pt_cnt < PT_CW'(PT_DEPTH));
    assign ct_room  = (CTW'(ct_cnt) < ct_tgt_live) && (ct_cnt < CT_CW'(CT_DEPTH));
    assign ld_ready = is_idle && (ld_sel ? ct_room : pt_room);
    assign pt_wr    = ld_valid && ld_ready && !ld_sel;
    assign ct_wr    = ld_valid && ld_ready && ld_sel;

    assign go_ok = (PTW'(pt_cnt) == pt_tgt_live)
                && (CTW'(ct_cnt) == ct_tgt_live)
                && ((33'(n_V) + 33'd1) <= 33'(N_MAX))
                && ((9'(k_V) + 9'd1) <= 9'(K_MAX));

    // State register.
    always_ff @(posedge clk_in1 or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; core done inputs are only looked at in their RUN state.
    always_comb begin
        state_nxt = state;
        go_acc    = 1'b0;
        go_rej    = 1'b0;
        case (state)
            S_IDLE: begin
                if (go) begin
                    if (go_ok) begin
                        go_acc    = 1'b1;
                        state_nxt = S_START_1;
                    end else begin
                        go_rej    = 1'b1;
                    end
                end
            end
            S_START_1: state_nxt = S_RUN_1;
            S_RUN_1:   if (ap_done_1) state_nxt = S_START_2;
            S_START_2: state_nxt = S_RUN_2;
            S_RUN_2:   if (ap_done_2) state_nxt = S_DONE;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Registered status and handshake outputs, decoded from the next state.
    always_ff @(posedge clk_in1 or posedge reset) begin
        if (reset) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            cfg_err    <= 1'b0;
            ap_start_1 <= 1'b0;
            ap_start_2 <= 1'b0;
        end else begin
            busy       <= (state_nxt != S_IDLE);
            done       <= (state_nxt == S_DONE);
            cfg_err    <= go_rej;
            ap_start_1 <= (state_nxt == S_START_1);
            ap_start_2 <= (state_nxt == S_START_2);
        end
    end

    // Latch stream targets on an accepted go so the run ignores n_V/k_V changes.
    always_ff @(posedge clk_in1 or posedge reset) begin
        if (reset) begin
            pt_tgt <= '0;
            ct_tgt <= '0;
        end else if (go_acc) begin
            pt_tgt <= PT_CW'(pt_tgt_live);
            ct_tgt <= CT_CW'(ct_tgt_live);
        end
    end

    // Saturating count of cycles spent in either RUN state.
    always_ff @(posedge clk_in1 or posedge reset) begin
        if (reset) begin
            cycle_count <= '0;
        end else if (go_acc) begin
            cycle_count <= '0;
        end else if (in_run && (cycle_count != 32'hFFFF_FFFF)) begin
            cycle_count <= cycle_count + 32'd1;
        end
    end

    // Sticky flag for any read issued against an empty stream.
    always_ff @(posedge clk_in1 or posedge reset) begin
        if (reset) begin
            err_underrun <= 1'b0;
        end else if (pt_under || ct_under) begin
            err_underrun <= 1'b1;
        end
    end

    feeder_buf #(
        .AW     (PT_AW),
        .CW     (PT_CW),
        .DATA_W (DATA_W)
    ) u_pt_buf (
        .clk      (clk_in1),
        .rst      (reset),
        .wr_en    (pt_wr),
        .wr_data  (ld_data),
        .cnt_clr  (cnt_clr),
        .wr_cnt   (pt_cnt),
        .ptr_clr  (ptr_clr),
        .run      (in_run),
        .target   (pt_tgt),
        .read     (data_points_in_read),
        .dout     (data_points_in_dout),
        .empty_n  (data_points_in_empty_n),
        .underrun (pt_under)
    );

    feeder_buf #(
        .AW     (CT_AW),
        .CW     (CT_CW),
        .DATA_W (DATA_W)
    ) u_ct_buf (
        .clk      (clk_in1),
        .rst      (reset),
        .wr_en    (ct_wr),
        .wr_data  (ld_data),
        .cnt_clr  (cnt_clr),
        .wr_cnt   (ct_cnt),
        .ptr_clr  (ptr_clr),
        .run      (in_run),
        .target   (ct_tgt),
        .read     (centres_in_read),
        .dout     (centres_in_dout),
        .empty_n  (centres_in_empty_n),
        .underrun (ct_under)
    );

endmodule

// File: doc/kmeans_stream_feeder.md
Name: kmeans_stream_feeder

Overview:
- Upstream stage of the two-phase Lloyd's k-means HLS core.
- Buffers data points and initial centres in on-chip RAM, then serves them through the core's ap_fifo read interfaces (dout / empty_n / read).
- Sequences the ap_start_1/ap_done_1 and ap_start_2/ap_done_2 handshakes and counts processing cycles.
- Replaces the behavioural stimulus feeder so the same sequencing is available in hardware.

Parameters:
N_MAX, 1024, max data points buffered
K_MAX, 16, max centres buffered
D, 3, dimensions per point (words per point/centre)
DATA_W, 32, word width

Ports:
clk_in1  in  1  system clock
reset  in  1  asynchronous, active-high reset
n_V  in  32  number of points minus 1; sampled in IDLE
k_V  in  8  number of centres minus 1; sampled in IDLE
ld_sel  in  1  0 = point buffer, 1 = centre buffer
ld_valid  in  1  load word valid
ld_data  in  DATA_W  load word
ld_ready  out  1  load word accepted when ld_valid && ld_ready
go  in  1  start both phases
busy  out  1  high in all states except IDLE
done  out  1  one-cycle pulse on leaving DONE
cfg_err  out  1  one-cycle pulse when go is rejected
err_underrun  out  1  sticky; a read was seen while the matching empty_n was low
cycle_count  out  32  cycles spent in RUN_1 + RUN_2
ap_start_1  out  1  phase-1 start pulse
ap_done_1  in  1  phase-1 done
ap_start_2  out  1  phase-2 start pulse
ap_done_2  in  1  phase-2 done
data_points_in_dout  out  DATA_W  point word
data_points_in_empty_n  out  1  point word available
data_points_in_read  in  1  consume point word
centres_in_dout  out  DATA_W  centre word
centres_in_empty_n  out  1  centre word available
centres_in_read  in  1  consume centre word

Behaviour:
- Reset (async, active-high):
  - state = IDLE.
  - All outputs 0, except ld_ready = 1 when its buffer is not full.
  - Write counts, read pointers, cycle_count and err_underrun cleared.
  - RAM contents are not cleared.
  - Reset mid-RUN aborts immediately; the core sees empty_n = 0 and no further start pulses.
- Targets: PT = D*(n_V+1), CT = D*(k_V+1), both computed at full width (no truncation).
- Load (IDLE only):
  - ld_ready = (state == IDLE) && (selected write count < selected target).
  - An accepted word is written at address = count; the count then increments.
  - Words beyond the target, or offered outside IDLE, are not accepted.
- go is honoured only in IDLE:
  - Accepted when pt_cnt == PT, ct_cnt == CT, n_V+1 <= N_MAX and k_V+1 <= K_MAX. Then PT/CT are latched, cycle_count cleared, and the FSM moves to START_1.
  - Otherwise cfg_err pulses for one cycle and the FSM stays in IDLE.
  - go outside IDLE is ignored.
- FSM:
  - IDLE -> START_1 on accepted go.
  - START_1 (ap_start_1 = 1, both read pointers reset to 0) -> RUN_1.
  - RUN_1 -> START_2 when ap_done_1 = 1.
  - START_2 (ap_start_2 = 1, pointers reset to 0) -> RUN_2.
  - RUN_2 -> DONE when ap_done_2 = 1.
  - DONE (done = 1) -> IDLE; load counts are cleared on this transition.
  - ap_done_x is sampled only in RUN_x. A done asserted during START_x or IDLE is ignored.
- Streams (identical for points and centres):
  - Show-ahead behaviour. empty_n = RUN_x && (rd_ptr < target).
  - dout is registered and equals mem[rd_ptr] whenever empty_n = 1.
  - read && empty_n advances rd_ptr; the next word is on dout on the following cycle. A read on every cycle is sustained (one word per cycle).
  - read while empty_n = 0 sets err_underrun, which is cleared only by reset; rd_ptr is unchanged.
  - A full pass of each buffer is available in each phase.
- cycle_count increments on every cycle in RUN_1 or RUN_2 and saturates at 2^32-1.
- Simultaneous events:
  - A read on the last word and ap_done_x in the same cycle: the pointer advances and the state advances.
  - A point read and a centre read in the same cycle are independent.

Decomposition:
- Package kmeans_feeder_pkg holds:
  - the state encoding (IDLE, START_1, RUN_1, START_2, RUN_2, DONE);
  - address-width constants $clog2(D*N_MAX) and $clog2(D*K_MAX).
- One sub-module, feeder_buf: a simple dual-port RAM plus write counter, read pointer and registered show-ahead output. It is instantiated twice (points, centres).

Test Plan:
1. N=128, K=4, D=3: load 384 point words (value = index) and 12 centre words, pulse go -> ap_start_1 for exactly 1 cycle; data_points_in_dout = 0,1,2,…,383 under continuous read; empty_n falls after word 383; centres give 12 words.
2. Assert ap_done_1 after 500 RUN_1 cycles -> ap_start_2 pulses; streams restart at word 0; ap_done_2 after 300 RUN_2 cycles -> done pulse, cycle_count = 800, busy = 0.
3. go with only 383 of 384 point words loaded -> cfg_err pulse, state stays IDLE; go with n_V = 1024 (N_MAX = 1024) -> cfg_err.
4. Read asserted on the cycle after the final centre word -> err_underrun = 1 and stays high; pointer unchanged.
5. Assert reset mid-RUN_1 after 50 point reads -> all outputs 0, empty_n = 0 immediately; reload and rerun -> the stream restarts at word 0.
6. Offer a 13th centre word when K=4 -> ld_ready = 0, word not written; ap_done_2 asserted during START_2 -> ignored; DONE is reached only on a later ap_done_2.
